// File: rtl/fwd_hazard_ctrl.sv
// EX-stage operand-forwarding select and load-use stall controller.
// Optional perf counters are enabled with the FWD_PERF_CNT_EN macro.
module fwd_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_issue_valid,
   output logic              o_issue_ready,
   input  logic [REG_AW-1:0] i_issue_rs1,
   input  logic [REG_AW-1:0] i_issue_rs2,
   input  logic [REG_AW-1:0] i_issue_rd,
   input  logic              i_issue_wen,
   input  logic              i_issue_is_load,
   input  logic              i_hold,
   input  logic              i_flush,
   output logic [1:0]        o_fwd_a_sel,
   output logic [1:0]        o_fwd_b_sel,
   output logic              o_ex_valid
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  o_stall_cnt,
   output logic [CNT_W-1:0]  o_fwd_cnt
`endif
);

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_EX  = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;

   logic              r_ex_v;
   logic [REG_AW-1:0] r_ex_rd;
   logic              r_ex_wen;
   logic              r_ex_ld;
   logic              r_mem_v;
   logic [REG_AW-1:0] r_mem_rd;
   logic              r_mem_wen;
   logic [1:0]        r_a_sel;
   logic [1:0]        r_b_sel;

   logic              w_ex_m1;
   logic              w_ex_m2;
   logic              w_mem_m1;
   logic              w_mem_m2;
   logic              w_hazard;
   logic              w_ready;
   logic              w_issue;
   logic [1:0]        w_a_sel;
   logic [1:0]        w_b_sel;

   // x0 is hardwired zero, so it never matches a producer.
   always_comb begin
      w_ex_m1  = r_ex_v  & r_ex_wen  & (r_ex_rd  == i_issue_rs1) & (i_issue_rs1 != '0);
      w_ex_m2  = r_ex_v  & r_ex_wen  & (r_ex_rd  == i_issue_rs2) & (i_issue_rs2 != '0);
      w_mem_m1 = r_mem_v & r_mem_wen & (r_mem_rd == i_issue_rs1) & (i_issue_rs1 != '0);
      w_mem_m2 = r_mem_v & r_mem_wen & (r_mem_rd == i_issue_rs2) & (i_issue_rs2 != '0);
      w_hazard = i_issue_valid & r_ex_ld & (w_ex_m1 | w_ex_m2);
      w_ready  = ~i_hold & ~w_hazard;
      w_issue  = i_issue_valid & w_ready;
      w_a_sel  = w_ex_m1 ? SEL_EX : (w_mem_m1 ? SEL_MEM : SEL_RF);
      w_b_sel  = w_ex_m2 ? SEL_EX : (w_mem_m2 ? SEL_MEM : SEL_RF);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_ex_v    <= 1'b0;
         r_ex_rd   <= '0;
         r_ex_wen  <= 1'b0;
         r_ex_ld   <= 1'b0;
         r_mem_v   <= 1'b0;
         r_mem_rd  <= '0;
         r_mem_wen <= 1'b0;
         r_a_sel   <= SEL_RF;
         r_b_sel   <= SEL_RF;
      end else if (!i_hold) begin
         r_mem_v   <= r_ex_v;
         r_mem_rd  <= r_ex_rd;
         r_mem_wen <= r_ex_wen;
         if (w_issue) begin
            r_ex_v   <= 1'b1;
            r_ex_rd  <= i_issue_rd;
            r_ex_wen <= i_issue_wen;
            r_ex_ld  <= i_issue_is_load;
            r_a_sel  <= w_a_sel;
            r_b_sel  <= w_b_sel;
         end else begin
            r_ex_v   <= 1'b0;
            r_ex_rd  <= '0;
            r_ex_wen <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_a_sel  <= SEL_RF;
            r_b_sel  <= SEL_RF;
         end
      end
   end

`ifdef FWD_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_fwd_cnt;
   logic [1:0]       w_nfwd;

   assign w_nfwd = {1'b0, |w_a_sel} + {1'b0, |w_b_sel};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         if (w_hazard && !i_hold && !i_flush)
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_issue && !i_flush)
            r_fwd_cnt <= r_fwd_cnt + CNT_W'(w_nfwd);
      end
   end

   assign o_stall_cnt = r_stall_cnt;
   assign o_fwd_cnt   = r_fwd_cnt;
`endif

   assign o_issue_ready = w_ready;
   assign o_fwd_a_sel   = r_a_sel;
   assign o_fwd_b_sel   = r_b_sel;
   assign o_ex_valid    = r_ex_v;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; expected EX-stage outputs are queued
// per driven cycle and checked after the following clock edge.
module tb_fwd_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic        issue_ready;
   logic [4:0]  issue_rs1, issue_rs2, issue_rd;
   logic        issue_wen, issue_is_load;
   logic        hold, flush;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic        ex_valid;
`ifdef FWD_PERF_CNT_EN
   logic [31:0] stall_cnt, fwd_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [4:0] exp_q[$];

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_issue_valid   (issue_valid),
      .o_issue_ready   (issue_ready),
      .i_issue_rs1     (issue_rs1),
      .i_issue_rs2     (issue_rs2),
      .i_issue_rd      (issue_rd),
      .i_issue_wen     (issue_wen),
      .i_issue_is_load (issue_is_load),
      .i_hold          (hold),
      .i_flush         (flush),
      .o_fwd_a_sel     (fwd_a_sel),
      .o_fwd_b_sel     (fwd_b_sel),
      .o_ex_valid      (ex_valid)
`ifdef FWD_PERF_CNT_EN
      ,
      .o_stall_cnt     (stall_cnt),
      .o_fwd_cnt       (fwd_cnt)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // exp_out = {ex_valid, a_sel, b_sel} after the edge
   task automatic step(input string tag, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic ld,
                       input logic hd, input logic fl, input logic exp_rdy, input logic [4:0] exp_out);
      logic [4:0] e;
      @(negedge clk);
      issue_valid = v; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
      issue_wen = wen; issue_is_load = ld; hold = hd; flush = fl;
      #1;
      check_val({tag, ".ready"}, {31'd0, issue_ready}, {31'd0, exp_rdy});
      exp_q.push_back(exp_out);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_val({tag, ".ex_valid"}, {31'd0, ex_valid}, {31'd0, e[4]});
      check_val({tag, ".a_sel"}, {30'd0, fwd_a_sel}, {30'd0, e[3:2]});
      check_val({tag, ".b_sel"}, {30'd0, fwd_b_sel}, {30'd0, e[1:0]});
   endtask

   task automatic clr(input string tag);
      step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b0_00_00);
   endtask

   initial begin
      rst = 1'b1; issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      issue_wen = 1'b0; issue_is_load = 1'b0; hold = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("rst.a_sel", {30'd0, fwd_a_sel}, 32'd0);
      check_val("rst.b_sel", {30'd0, fwd_b_sel}, 32'd0);
      check_val("rst.ex_valid", {31'd0, ex_valid}, 32'd0);
      check_val("rst.ready", {31'd0, issue_ready}, 32'd1);
`ifdef FWD_PERF_CNT_EN
      check_val("rst.stall_cnt", stall_cnt, 32'd0);
      check_val("rst.fwd_cnt", fwd_cnt, 32'd0);
`endif

      // distance 1
      step("d1.prod", 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_00_00);
      step("d1.cons", 1'b1, 5'd5, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_01_00);
      clr("d1.clr");

      // distance 2 through MEM
      step("d2.prod", 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_00_00);
      step("d2.nop",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0_00_00);
      step("d2.cons", 1'b1, 5'd3, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_00_10);
      clr("d2.clr");

      // both slots match: EX wins
      step("pr.p1",   1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_00_00);
      step("pr.p2",   1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_00_00);
      step("pr.cons", 1'b1, 5'd5, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_01_00);
      clr("pr.clr");

      // load-use: one bubble, then MEM forward
      step("lu.load", 1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b1_00_00);
      step("lu.stall",1'b1, 5'd6, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0_00_00);
      step("lu.issue",1'b1, 5'd6, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_10_00);
`ifdef FWD_PERF_CNT_EN
      check_val("lu.stall_cnt", stall_cnt, 32'd1);
`endif
      clr("lu.clr");

      // x0 load never stalls or forwards
      step("x0.load", 1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b1_00_00);
      step("x0.cons", 1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_00_00);
      clr("x0.clr");

      // flush during load-use stall clears both slots
      step("fl.load", 1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b1_00_00);
      step("fl.stall",1'b1, 5'd6, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'b0_00_00);
      step("fl.after",1'b1, 5'd6, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_00_00);

      // hold freezes outputs and both slots
      step("hd.setup",1'b1, 5'd13, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_01_00);
      for (int i = 0; i < 3; i++)
         step("hd.hold", 1'b1, 5'd14, 5'd0, 5'd20, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b1_01_00);
      step("hd.rel",  1'b1, 5'd14, 5'd13, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_01_10);

      // flush with hold behaves as flush
      step("fh.both", 1'b1, 5'd15, 5'd14, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'b0_00_00);
      step("fh.after",1'b1, 5'd15, 5'd14, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b1_00_00);

`ifdef FWD_PERF_CNT_EN
      check_val("end.stall_cnt", stall_cnt, 32'd1);
      check_val("end.fwd_cnt", fwd_cnt, 32'd7);
`endif
      check_val("end.queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
